// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell stepped LSB-first over WIDTH cycles.
// Subtraction runs as A + ~B + ~borrow_in, so carry_out=1 means "no borrow".
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a_input,
  input  logic [WIDTH-1:0] b_input,
  input  logic             c_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_nxt;
  logic [CW-1:0]    cnt;
  logic             carry, carry_nxt, bit_a, bit_b, bit_s;
  logic             accept, last;

  assign accept    = start && ((state == IDLE) || (state == DONE));
  assign last      = (cnt == LAST);
  assign bit_a     = a_reg[cnt];
  assign bit_b     = b_reg[cnt];
  assign bit_s     = bit_a ^ bit_b ^ carry;
  assign carry_nxt = (bit_a & bit_b) | (bit_a & carry) | (bit_b & carry);

  always_comb begin
    res_nxt      = res_reg;
    res_nxt[cnt] = bit_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // sum/carry_out/overflow only change on the final bit, so they hold across IDLE and RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (accept) begin
      a_reg <= a_input;
      b_reg <= mode ? ~b_input : b_input;
      carry <= c_in ^ mode;
      cnt   <= '0;
    end else if (state == RUN) begin
      res_reg <= res_nxt;
      carry   <= carry_nxt;
      if (last) begin
        sum       <= res_nxt;
        carry_out <= carry_nxt;
        overflow  <= carry ^ carry_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_serial_add_sub.sv
// Scoreboard bench for serial_add_sub: WIDTH=8 directed scenarios plus WIDTH=2 and WIDTH=32 sweeps.
module tb_serial_add_sub;

  typedef struct { logic [31:0] s; logic co; logic ov; } res_t;
  typedef struct { logic md; logic [7:0] a; logic [7:0] b; logic ci; logic [7:0] s; logic co; logic ov; } vec_t;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc8     = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  res_t q8[$];
  res_t q2[$];
  res_t q32[$];

  logic        start8, mode8, cin8, cout8, ovf8, busy8, done8;
  logic [7:0]  a8, b8, sum8;
  logic        start2, mode2, cin2, cout2, ovf2, busy2, done2;
  logic [1:0]  a2, b2, sum2;
  logic        start32, mode32, cin32, cout32, ovf32, busy32, done32;
  logic [31:0] a32, b32, sum32;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_add_sub #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a_input(a8), .b_input(b8), .c_in(cin8),
    .sum(sum8), .carry_out(cout8), .overflow(ovf8), .busy(busy8), .done(done8));

  serial_add_sub #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a_input(a2), .b_input(b2), .c_in(cin2),
    .sum(sum2), .carry_out(cout2), .overflow(ovf2), .busy(busy2), .done(done2));

  serial_add_sub #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .mode(mode32), .a_input(a32), .b_input(b32), .c_in(cin32),
    .sum(sum32), .carry_out(cout32), .overflow(ovf32), .busy(busy32), .done(done32));

  // Arithmetic reference: overflow from operand/result sign bits, carry from a wide sum.
  function automatic res_t model(input int w, input logic md, input logic [31:0] a,
                                 input logic [31:0] b, input logic ci);
    logic [63:0] mask, aa, bb, full;
    res_t r;
    mask  = (64'd1 << w) - 64'd1;
    aa    = {32'd0, a} & mask;
    bb    = md ? (~{32'd0, b} & mask) : ({32'd0, b} & mask);
    full  = aa + bb + {63'd0, ci ^ md};
    r.s   = full[31:0] & mask[31:0];
    r.co  = full[w];
    r.ov  = (aa[w-1] == bb[w-1]) && (full[w-1] != aa[w-1]);
    return r;
  endfunction

  task automatic issue8(input logic md, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input res_t e);
    @(negedge clk);
    start8 = 1'b1; mode8 = md; a8 = a; b8 = b; cin8 = ci;
    @(posedge clk);
    #1;
    acc8 = cyc;
    q8.push_back(e);
    start8 = 1'b0; mode8 = ~md; a8 = ~a; b8 = 8'($urandom); cin8 = ~ci;
  endtask

  task automatic wait_done8(output bit found, output int nbusy);
    found = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        found = 1'b1;
        break;
      end
      if (busy8) nbusy++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'd0) begin
      failures++;
      $display("FAIL reset_outputs8: got %h required 000", {sum8, cout8, ovf8, busy8, done8});
    end
    checks++;
    if ({sum32, sum2, busy2, busy32, done2, done32} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs_other: got %h required 0", {sum32, sum2, busy2, busy32, done2, done32});
    end
    rst = 1'b0;
  endtask

  task automatic test_arith();
    vec_t tv[7] = '{
      '{1'b0, 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0},
      '{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0},
      '{1'b0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1},
      '{1'b0, 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1},
      '{1'b1, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0},
      '{1'b1, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1},
      '{1'b1, 8'h10, 8'h0F, 1'b1, 8'h00, 1'b1, 1'b0}};
    res_t e, r;
    bit found;
    int nbusy;
    for (int i = 0; i < 7; i++) begin
      e.s = {24'd0, tv[i].s}; e.co = tv[i].co; e.ov = tv[i].ov;
      issue8(tv[i].md, tv[i].a, tv[i].b, tv[i].ci, e);
      wait_done8(found, nbusy);
      checks++;
      if (!found || q8.size() == 0) begin
        failures++;
        $display("FAIL arith_done_timeout[%0d]: done never seen", i);
        q8.delete();
        continue;
      end
      r = q8.pop_front();
      if ({sum8, cout8, ovf8} !== {r.s[7:0], r.co, r.ov}) begin
        failures++;
        $display("FAIL arith_result[%0d]: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                 i, sum8, cout8, ovf8, r.s[7:0], r.co, r.ov);
      end
      checks++;
      if (cyc - acc8 != 8) begin
        failures++;
        $display("FAIL arith_latency[%0d]: got %0d required 8", i, cyc - acc8);
      end
      checks++;
      if (nbusy != 8) begin
        failures++;
        $display("FAIL arith_busy_cycles[%0d]: got %0d required 8", i, nbusy);
      end
      checks++;
      if (busy8 !== 1'b0) begin
        failures++;
        $display("FAIL arith_busy_with_done[%0d]: got %b required 0", i, busy8);
      end
      @(negedge clk);
      checks++;
      if (done8 !== 1'b0) begin
        failures++;
        $display("FAIL arith_done_width[%0d]: got %b required 0", i, done8);
      end
    end
  endtask

  task automatic test_start_in_run();
    res_t r;
    bit found;
    int nbusy, extra;
    issue8(1'b0, 8'h12, 8'h34, 1'b1, model(8, 1'b0, 32'h12, 32'h34, 1'b1));
    repeat (2) @(negedge clk);
    start8 = 1'b1; mode8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    wait_done8(found, nbusy);
    checks++;
    if (!found || q8.size() == 0) begin
      failures++;
      $display("FAIL run_start_timeout: done never seen");
      q8.delete();
    end else begin
      r = q8.pop_front();
      if ({sum8, cout8, ovf8} !== {r.s[7:0], r.co, r.ov}) begin
        failures++;
        $display("FAIL run_start_result: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                 sum8, cout8, ovf8, r.s[7:0], r.co, r.ov);
      end
      checks++;
      if (cyc - acc8 != 8) begin
        failures++;
        $display("FAIL run_start_latency: got %0d required 8", cyc - acc8);
      end
    end
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL run_start_ignored: got %0d busy/done cycles required 0", extra);
    end
  endtask

  task automatic test_reset_mid_run();
    res_t r;
    bit found;
    int nbusy, extra;
    issue8(1'b0, 8'h3C, 8'h05, 1'b0, model(8, 1'b0, 32'h3C, 32'h05, 1'b0));
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({sum8, cout8, ovf8, busy8, done8} !== 12'd0) begin
      failures++;
      $display("FAIL midrun_reset_outputs: got %h required 000", {sum8, cout8, ovf8, busy8, done8});
    end
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) extra++;
    end
    checks++;
    if (extra != 0) begin
      failures++;
      $display("FAIL midrun_no_done: got %0d done cycles required 0", extra);
    end
    issue8(1'b0, 8'h01, 8'h01, 1'b0, model(8, 1'b0, 32'h01, 32'h01, 1'b0));
    wait_done8(found, nbusy);
    checks++;
    if (!found || q8.size() == 0) begin
      failures++;
      $display("FAIL post_reset_timeout: done never seen");
      q8.delete();
    end else begin
      r = q8.pop_front();
      if ({sum8, cout8, ovf8} !== {8'h02, 1'b0, 1'b0} || r.s[7:0] !== 8'h02) begin
        failures++;
        $display("FAIL post_reset_result: got sum=%h co=%b ov=%b required sum=02 co=0 ov=0",
                 sum8, cout8, ovf8);
      end
      checks++;
      if (cyc - acc8 != 8) begin
        failures++;
        $display("FAIL post_reset_latency: got %0d required 8", cyc - acc8);
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t r;
    bit found;
    int nbusy, d1, acc1;
    d1 = 0;
    @(negedge clk);
    start8 = 1'b1; mode8 = 1'b0; a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0;
    @(posedge clk);
    #1;
    acc1 = cyc;
    q8.push_back(model(8, 1'b0, 32'h10, 32'h20, 1'b0));
    q8.push_back(model(8, 1'b1, 32'h10, 32'h20, 1'b0));
    mode8 = 1'b1;
    for (int op = 0; op < 2; op++) begin
      wait_done8(found, nbusy);
      checks++;
      if (!found || q8.size() == 0) begin
        failures++;
        $display("FAIL b2b_timeout[%0d]: done never seen", op);
        q8.delete();
        break;
      end
      r = q8.pop_front();
      if ({sum8, cout8, ovf8} !== {r.s[7:0], r.co, r.ov}) begin
        failures++;
        $display("FAIL b2b_result[%0d]: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                 op, sum8, cout8, ovf8, r.s[7:0], r.co, r.ov);
      end
      checks++;
      if (op == 0 && cyc - acc1 != 8) begin
        failures++;
        $display("FAIL b2b_first_latency: got %0d required 8", cyc - acc1);
      end else if (op == 1 && cyc - d1 != 9) begin
        failures++;
        $display("FAIL b2b_done_spacing: got %0d required 9", cyc - d1);
      end
      d1 = cyc;
      if (op == 0) begin
        @(negedge clk);
        checks++;
        if ({busy8, done8} !== 2'b10) begin
          failures++;
          $display("FAIL b2b_rebusy: got busy=%b done=%b required busy=1 done=0", busy8, done8);
        end
        start8 = 1'b0;
      end
    end
    start8 = 1'b0;
  endtask

  task automatic test_w2_exhaustive();
    res_t r;
    bit found;
    for (int md = 0; md < 2; md++)
      for (int a = 0; a < 4; a++)
        for (int b = 0; b < 4; b++)
          for (int ci = 0; ci < 2; ci++) begin
            @(negedge clk);
            start2 = 1'b1; mode2 = md[0]; a2 = a[1:0]; b2 = b[1:0]; cin2 = ci[0];
            @(posedge clk);
            #1;
            q2.push_back(model(2, md[0], 32'(a), 32'(b), ci[0]));
            start2 = 1'b0; a2 = ~a2; b2 = ~b2; cin2 = ~cin2;
            found = 1'b0;
            for (int i = 0; i < 10; i++) begin
              @(negedge clk);
              if (done2) begin
                found = 1'b1;
                break;
              end
            end
            checks++;
            if (!found || q2.size() == 0) begin
              failures++;
              $display("FAIL w2_timeout: md=%0d a=%0d b=%0d ci=%0d", md, a, b, ci);
              q2.delete();
            end else begin
              r = q2.pop_front();
              if ({sum2, cout2, ovf2} !== {r.s[1:0], r.co, r.ov}) begin
                failures++;
                $display("FAIL w2_result: md=%0d a=%0d b=%0d ci=%0d got %b%b%b required %b%b%b",
                         md, a, b, ci, sum2, cout2, ovf2, r.s[1:0], r.co, r.ov);
              end
            end
          end
  endtask

  task automatic test_w32_random();
    res_t r;
    bit found;
    logic md, ci;
    logic [31:0] a, b;
    for (int n = 0; n < 40; n++) begin
      md = 1'($urandom); ci = 1'($urandom); a = $urandom; b = $urandom;
      if (n == 0) begin md = 1'b0; a = 32'h7FFF_FFFF; b = 32'h1;         ci = 1'b0; end
      if (n == 1) begin md = 1'b1; a = 32'h8000_0000; b = 32'h1;         ci = 1'b0; end
      if (n == 2) begin md = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; ci = 1'b1; end
      @(negedge clk);
      start32 = 1'b1; mode32 = md; a32 = a; b32 = b; cin32 = ci;
      @(posedge clk);
      #1;
      q32.push_back(model(32, md, a, b, ci));
      start32 = 1'b0; a32 = $urandom; b32 = $urandom;
      found = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done32) begin
          found = 1'b1;
          break;
        end
      end
      checks++;
      if (!found || q32.size() == 0) begin
        failures++;
        $display("FAIL w32_timeout: op %0d", n);
        q32.delete();
      end else begin
        r = q32.pop_front();
        if ({sum32, cout32, ovf32} !== {r.s, r.co, r.ov}) begin
          failures++;
          $display("FAIL w32_result[%0d]: md=%b a=%h b=%h ci=%b got %h %b %b required %h %b %b",
                   n, md, a, b, ci, sum32, cout32, ovf32, r.s, r.co, r.ov);
        end
      end
    end
  endtask

  initial begin
    start8 = 1'b0; mode8 = 1'b0; cin8 = 1'b0; a8 = '0; b8 = '0;
    start2 = 1'b0; mode2 = 1'b0; cin2 = 1'b0; a2 = '0; b2 = '0;
    start32 = 1'b0; mode32 = 1'b0; cin32 = 1'b0; a32 = '0; b32 = '0;
    test_reset();
    test_arith();
    test_start_in_run();
    test_reset_mid_run();
    test_back_to_back();
    test_w2_exhaustive();
    test_w32_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
